seq_onehot_decoder: RTL and testbench

Parametrised, registered N-to-2^N one-hot decoder. It is the clocked successor to the team's combinational enable-gated decoders. Besides plain select decoding, it has an auto-scan mode that walks the active output up or down with a programmable dwell time, a hold mode, and a valid/ready load handshake. It is used as a channel/row strobe generator feeding downstream enable lines.

---
 rtl/seq_onehot_decoder.sv | 108 ++++++++++
 tb/tb_seq_onehot_decoder.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_onehot_decoder.sv
// Registered N-to-2^N one-hot strobe generator with decode, scan-up,
// scan-down and hold modes behind a valid/ready select load.
module seq_onehot_decoder #(
    parameter int N           = 3,
    parameter int STEP_CYCLES = 4,
    parameter bit ACTIVE_LOW  = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [1:0]        mode,
    input  logic              in_valid,
    input  logic [N-1:0]      in_sel,
    output logic              in_ready,
    output logic [2**N-1:0]   out_onehot,
    output logic [N-1:0]      out_sel,
    output logic              out_valid,
    output logic              wrap
);

    localparam int M  = 2 ** N;
    localparam int CW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

    typedef enum logic [1:0] {
        MD_DEC  = 2'b00,
        MD_UP   = 2'b01,
        MD_DN   = 2'b10,
        MD_HOLD = 2'b11
    } mode_t;

    mode_t           w_mode;
    mode_t           r_mode;
    logic [N-1:0]    r_sel;
    logic [M-1:0]    r_hot;
    logic            r_valid;
    logic            r_wrap;
    logic [CW-1:0]   r_cnt;

    logic            w_accept;
    logic            w_scan;
    logic            w_mchg;
    logic            w_last;
    logic            w_up;
    logic [N-1:0]    w_next_sel;
    logic            w_wrap_hit;
    logic            w_live;

    function automatic logic [M-1:0] dec(input logic [N-1:0] s);
        dec    = '0;
        dec[s] = 1'b1;
    endfunction

    assign w_mode     = mode_t'(mode);
    assign in_ready   = en && rst_n && (w_mode != MD_HOLD);
    assign w_accept   = in_valid && in_ready;
    assign w_scan     = (w_mode == MD_UP) || (w_mode == MD_DN);
    assign w_mchg     = (w_mode != r_mode);
    assign w_last     = (r_cnt == CW'(STEP_CYCLES - 1));
    assign w_up       = (w_mode == MD_UP);
    assign w_next_sel = w_up ? r_sel + N'(1) : r_sel - N'(1);
    assign w_wrap_hit = w_up ? (&r_sel) : ~(|r_sel);

    // en low blanks the strobes without disturbing the frozen state
    assign w_live     = en && r_valid;
    assign out_onehot = w_live ? (r_hot ^ {M{ACTIVE_LOW}}) : {M{ACTIVE_LOW}};
    assign out_sel    = r_sel;
    assign out_valid  = w_live;
    assign wrap       = en && r_wrap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode  <= MD_DEC;
            r_sel   <= '0;
            r_hot   <= dec('0);
            r_valid <= 1'b0;
            r_wrap  <= 1'b0;
            r_cnt   <= '0;
        end else if (en) begin
            r_wrap <= 1'b0;
            r_mode <= w_mode;
            if (w_accept) begin
                r_sel   <= in_sel;
                r_hot   <= dec(in_sel);
                r_valid <= 1'b1;
                r_cnt   <= '0;
            end else if (w_scan) begin
                if (!r_valid) begin
                    r_valid <= 1'b1;
                    r_cnt   <= '0;
                end else if (w_mchg) begin
                    r_cnt <= '0;
                end else if (w_last) begin
                    r_cnt  <= '0;
                    r_sel  <= w_next_sel;
                    r_hot  <= dec(w_next_sel);
                    r_wrap <= w_wrap_hit;
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end else if (w_mchg) begin
                r_cnt <= '0;
            end
        end else begin
            r_wrap <= 1'b0;
        end
    end

endmodule

// File: tb/tb_seq_onehot_decoder.sv
// Randomised and directed check of seq_onehot_decoder, two configurations
// sharing stimulus, against a behavioural model.
module tb_seq_onehot_decoder;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [1:0] mode;
    logic       in_valid;
    logic [2:0] in_sel;

    logic       rdy0, rdy1;
    logic [7:0] hot0, hot1;
    logic [2:0] sel0, sel1;
    logic       val0, val1;
    logic       wr0, wr1;

    int unsigned n_pass = 0;
    int unsigned n_total = 0;
    bit done = 1'b0;

    seq_onehot_decoder #(.N(3), .STEP_CYCLES(2), .ACTIVE_LOW(1'b0)) u0 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode),
        .in_valid(in_valid), .in_sel(in_sel), .in_ready(rdy0),
        .out_onehot(hot0), .out_sel(sel0), .out_valid(val0), .wrap(wr0)
    );

    seq_onehot_decoder #(.N(3), .STEP_CYCLES(3), .ACTIVE_LOW(1'b1)) u1 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode),
        .in_valid(in_valid), .in_sel(in_sel), .in_ready(rdy1),
        .out_onehot(hot1), .out_sel(sel1), .out_valid(val1), .wrap(wr1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // model: position, enabled cycles spent at it since the dwell restarted
    int steps [2] = '{2, 3};
    bit alow  [2] = '{1'b0, 1'b1};
    int m_sel [2];
    int m_age [2];
    int m_pm  [2];
    bit m_val [2];
    bit m_wrap[2];

    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                m_sel[k] = 0; m_age[k] = 0; m_pm[k] = 0;
                m_val[k] = 1'b0; m_wrap[k] = 1'b0;
            end else if (en) begin
                m_wrap[k] = 1'b0;
                if (in_valid && mode != 2'd3) begin
                    m_sel[k] = int'(in_sel); m_val[k] = 1'b1; m_age[k] = 0;
                end else if (mode == 2'd1 || mode == 2'd2) begin
                    if (!m_val[k]) begin
                        m_val[k] = 1'b1; m_age[k] = 0;
                    end else if (int'(mode) != m_pm[k]) begin
                        m_age[k] = 0;
                    end else if (m_age[k] + 1 == steps[k]) begin
                        m_age[k] = 0;
                        if (mode == 2'd1) begin
                            m_wrap[k] = (m_sel[k] == 7);
                            m_sel[k] = (m_sel[k] + 1) % 8;
                        end else begin
                            m_wrap[k] = (m_sel[k] == 0);
                            m_sel[k] = (m_sel[k] + 7) % 8;
                        end
                    end else begin
                        m_age[k] = m_age[k] + 1;
                    end
                end else if (int'(mode) != m_pm[k]) begin
                    m_age[k] = 0;
                end
                m_pm[k] = int'(mode);
            end else begin
                m_wrap[k] = 1'b0;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    function automatic logic [7:0] exp_hot(input int k);
        logic [7:0] h;
        h = 8'h00;
        if (en && rst_n && m_val[k]) h[m_sel[k]] = 1'b1;
        if (alow[k]) h = ~h;
        return h;
    endfunction

    always @(negedge clk) begin
        if (!done) begin
            logic xr;
            xr = en && rst_n && (mode != 2'd3);
            chk("hot0", 32'(hot0), 32'(exp_hot(0)));
            chk("sel0", 32'(sel0), 32'(m_sel[0]));
            chk("val0", 32'(val0), 32'(en && m_val[0]));
            chk("wrap0", 32'(wr0), 32'(en && m_wrap[0]));
            chk("rdy0", 32'(rdy0), 32'(xr));
            chk("hot1", 32'(hot1), 32'(exp_hot(1)));
            chk("sel1", 32'(sel1), 32'(m_sel[1]));
            chk("val1", 32'(val1), 32'(en && m_val[1]));
            chk("wrap1", 32'(wr1), 32'(en && m_wrap[1]));
            chk("rdy1", 32'(rdy1), 32'(xr));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [1:0] md, input logic [2:0] s);
        mode = md; in_valid = 1'b1; in_sel = s;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        int up_seq [7] = '{6, 6, 7, 7, 0, 0, 1};
        int dn_seq [6] = '{1, 1, 0, 0, 7, 7};
        int st_seq [4] = '{4, 4, 4, 5};

        rst_n = 1'b0; en = 1'b1; mode = 2'd0; in_valid = 1'b0; in_sel = 3'd0;
        @(negedge clk);
        chk("rst_hot0", 32'(hot0), 32'h00);
        chk("rst_hot1", 32'(hot1), 32'hFF);
        chk("rst_val", 32'(val0), 32'd0);
        chk("rst_rdy", 32'(rdy0), 32'd0);
        tick();
        rst_n = 1'b1;

        load(2'd0, 3'd5);
        @(negedge clk);
        chk("dec5_hot", 32'(hot0), 32'h20);
        chk("dec5_sel", 32'(sel0), 32'd5);
        chk("dec5_val", 32'(val0), 32'd1);
        repeat (10) tick();
        chk("dec5_hold", 32'(hot0), 32'h20);

        load(2'd1, 3'd6);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            chk("up_sel", 32'(sel0), 32'(up_seq[i]));
            chk("up_wrap", 32'(wr0), 32'(i == 4));
            tick();
        end

        load(2'd2, 3'd1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("dn_sel", 32'(sel0), 32'(dn_seq[i]));
            chk("dn_wrap", 32'(wr0), 32'(i == 4));
            tick();
        end

        load(2'd0, 3'd2);
        @(negedge clk);
        chk("al_hot", 32'(hot1), 32'hFB);
        en = 1'b0;
        #1;
        chk("al_off_hot", 32'(hot1), 32'hFF);
        chk("al_off_val", 32'(val1), 32'd0);
        chk("al_off_rdy", 32'(rdy1), 32'd0);
        tick();
        en = 1'b1;
        #1;
        chk("al_on_hot", 32'(hot1), 32'hFB);

        load(2'd1, 3'd0);
        tick();
        tick();
        load(2'd1, 3'd4);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("prio_sel", 32'(sel1), 32'(st_seq[i]));
            tick();
        end
        mode = 2'd3;
        #1;
        chk("hold_rdy", 32'(rdy1), 32'd0);
        repeat (4) tick();
        chk("hold_sel", 32'(sel1), 32'd5);

        load(2'd1, 3'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_hot", 32'(hot0), 32'h00);
        chk("arst_sel", 32'(sel0), 32'd0);
        chk("arst_val", 32'(val0), 32'd0);
        chk("arst_wrap", 32'(wr0), 32'd0);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_val0", 32'(val0), 32'd0);
        tick();
        chk("rel_val1", 32'(val0), 32'd1);
        chk("rel_sel", 32'(sel0), 32'd0);
        tick();
        tick();
        chk("rel_step", 32'(sel0), 32'd1);

        for (int c = 0; c < 600; c++) begin
            rst_n    = ($urandom_range(0, 99) != 0);
            en       = ($urandom_range(0, 9) != 0);
            mode     = (c % 40 < 30) ? mode : 2'($urandom_range(0, 3));
            in_valid = ($urandom_range(0, 7) == 0);
            in_sel   = 3'($urandom_range(0, 7));
            tick();
        end

        @(negedge clk);
        done = 1'b1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
